// File: rtl/mod3_pkg.sv
// Shared types and the MSB-first remainder step for the serial mod-3 checker.
package mod3_pkg;

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   typedef logic [1:0] rem_t;

   localparam rem_t R0 = 2'd0;
   localparam rem_t R1 = 2'd1;
   localparam rem_t R2 = 2'd2;

   // (2*r + b) mod 3; the unreachable encoding 3 is folded onto remainder 0
   function automatic rem_t mod3_step(input rem_t r, input logic b);
      rem_t result;
      case (r)
         R1:      result = b ? R0 : R2;
         R2:      result = b ? R2 : R1;
         default: result = b ? R1 : R0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/mod3_step_cell.sv
// One combinational MSB-first remainder step, reusable in a parallel unroll.
module mod3_step_cell
   import mod3_pkg::*;
(
   input  rem_t r,
   input  logic b,
   output rem_t r_next
);

   assign r_next = mod3_step(r, b);

endmodule

// File: rtl/mod3_serial_msb.sv
// Serial MSB-first mod-3 divisibility checker: one bit per handshake,
// one registered result plus a done pulse per frame.
module mod3_serial_msb
   import mod3_pkg::*;
#(
   parameter int MAX_BITS = 16,
   parameter int CNT_W    = $clog2(MAX_BITS + 1)
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             bit_last,
   output logic             bit_ready,
   output logic             Z_out,
   output logic [1:0]       R_out,
   output logic [CNT_W-1:0] nbits_out,
   output logic             err_out,
   output logic             done,
   output logic             busy
);

   state_t           r_state;
   rem_t             r_rem;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;

   logic             w_accept;
   logic             w_inFrame;
   rem_t             w_remBase;
   rem_t             w_remNext;
   logic             w_cntSat;
   logic [CNT_W-1:0] w_cntNext;
   logic             w_ovfNext;

   assign bit_ready = (r_state != DONE);
   assign busy      = (r_state == ACC);
   assign w_accept  = bit_valid & bit_ready;
   assign w_inFrame = (r_state == ACC);

   // A bit accepted in IDLE starts a fresh operand from remainder 0
   assign w_remBase = w_inFrame ? r_rem : R0;

   mod3_step_cell u_step (
      .r      (w_remBase),
      .b      (bit_in),
      .r_next (w_remNext)
   );

   assign w_cntSat  = (r_cnt == CNT_W'(MAX_BITS));
   assign w_cntNext = w_inFrame ? (w_cntSat ? r_cnt : r_cnt + CNT_W'(1)) : CNT_W'(1);
   assign w_ovfNext = w_inFrame & (r_ovf | w_cntSat);

   // Results are loaded on the edge that accepts the last bit, so they and
   // done appear together during the single DONE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_rem     <= R0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         Z_out     <= 1'b1;
         R_out     <= R0;
         nbits_out <= '0;
         err_out   <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE, ACC: begin
               if (w_accept) begin
                  r_rem <= w_remNext;
                  r_cnt <= w_cntNext;
                  r_ovf <= w_ovfNext;
                  if (bit_last) begin
                     r_state   <= DONE;
                     R_out     <= w_remNext;
                     Z_out     <= (w_remNext == R0);
                     nbits_out <= w_cntNext;
                     err_out   <= w_ovfNext;
                     done      <= 1'b1;
                  end else begin
                     r_state <= ACC;
                  end
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mod3_serial_msb.md
Name: mod3_serial_msb

Overview:
- Sequential mod-3 divisibility checker. Consumes an unsigned operand one bit per handshake, MSB first (left-to-right).
- Complements the right-to-left structural cell array, which evaluates the same function LSB-first in combinational cells and ends in a final cell that drives Z_out.
- Used where the operand arrives serially and the cell array would be too wide.
- Emits remainder, divisible flag, bit count and overflow flag once per frame.

Parameters:
- MAX_BITS, 16, maximum operand length in bits that a frame may carry without flagging overflow.
- CNT_W, $clog2(MAX_BITS+1), width of the bit counter and nbits_out.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset; one clock domain only.
- bit_in  in  1  operand bit, MSB first.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_last  in  1  qualifies bit_in as the LSB, which ends the frame.
- bit_ready  out  1  block accepts a bit this cycle.
- Z_out  out  1  1 when the last completed operand ≡ 0 mod 3.
- R_out  out  2  remainder of the last completed operand: 0, 1 or 2.
- nbits_out  out  CNT_W  bits in the last completed frame, saturating at MAX_BITS.
- err_out  out  1  last completed frame exceeded MAX_BITS bits.
- done  out  1  one-cycle pulse: result outputs were updated this cycle.
- busy  out  1  a frame is in progress (state ACC).

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE, r=0, cnt=0.
  - Z_out=1, R_out=0, nbits_out=0, err_out=0, done=0, busy=0, bit_ready=1.
- Accept rule: a bit is accepted on a rising edge where bit_valid && bit_ready. When bit_valid=0, nothing changes and there is no timeout.
- bit_ready=1 in IDLE and ACC, and 0 in DONE. The stall is exactly one cycle per frame.
- Remainder step for each accepted bit: r_next = (2*r + bit_in) mod 3. Encodings:
  - 0,0→0; 0,1→1
  - 1,0→2; 1,1→0
  - 2,0→1; 2,1→2
  - Encoding 3 is unreachable. If reached, treat it as 0.
- FSM:
  - IDLE:
    - Accepted bit with bit_last=0 → ACC, with r=step(0,bit_in), cnt=1, ovf=0.
    - Accepted bit with bit_last=1 → DONE (single-bit frame).
  - ACC:
    - Accepted bit → r=step(r,bit_in), cnt=cnt+1 saturating at MAX_BITS.
    - ovf set if the accepted bit is number MAX_BITS+1 or later.
    - If bit_last=1 → DONE.
  - DONE (one cycle):
    - done=1; outputs registered from the final r, cnt and ovf.
    - Unconditional transition → IDLE.
- Latency: result outputs change and done=1 in the cycle after the edge that accepts the bit_last bit.
- Result outputs hold until the next frame completes. They do not change when a new frame starts.
- busy=1 only in ACC.
- The remainder stays exact regardless of operand length, because the arithmetic is modular. err_out only marks that nbits_out is saturated.
- Zero-length frames do not exist: the bit_last bit is always part of the operand.
- Reset mid-frame aborts the frame. No done pulse is emitted and all outputs return to reset values.
- bit_last while in DONE is ignored, because bit_ready=0.
- bit_in and bit_last are don't-care when bit_valid=0.

Decomposition:
- Shared package mod3_pkg holds:
  - state enum: IDLE, ACC, DONE.
  - remainder type (2 bits) and constants R0, R1, R2.
  - function mod3_step(r, b), used by RTL and by the bench reference model.
- One natural combinational sub-module: mod3_step_cell (inputs r, b; output r_next). It is the MSB-first counterpart of the structural array cell and is reused in a future parallel unroll.

Test Plan:
- Frame 1,1,0 (6) with bit_last on the 3rd bit, valid every cycle → one cycle later: done=1, Z_out=1, R_out=0, nbits_out=3, err_out=0.
- Frames 1,1,1 (7) then 1,0,1,1 (11), sent back-to-back → bit_ready=0 for exactly one cycle after each last bit; results R_out=1/Z_out=0, then R_out=2/Z_out=0, nbits 3 then 4.
- Operand 9 = 1,0,0,1 with bit_valid=0 gaps of 2 cycles between bits → no state change during gaps; done once; R_out=0, Z_out=1, nbits_out=4.
- Build with MAX_BITS=4, send 1,0,0,1,0 (18) → R_out=0, Z_out=1, nbits_out=4, err_out=1; the next frame of single bit 1 → R_out=1, err_out=0, nbits_out=1.
- Assert rst_n=0 for 1 ns mid-frame after 2 of 4 bits → immediately bit_ready=1, busy=0, Z_out=1, R_out=0, and no done pulse. A fresh frame 1,1 (3) afterwards → R_out=0, Z_out=1.
- Exhaustive check of all 8-bit operands 0..255 against a value%3 model → R_out and Z_out match on every done.
